// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency writers (loads, mfc0).
// Ports: clk/rst (async low); flush; ID source read and long-writer info
// (id_*); EX push of a writer (ex_push/ex_waddr); late write-back pop
// (lwb_valid/lwb_waddr); stallreq; status sb_count/sb_full/sb_empty/sb_err;
// and a saturating stall-cycle counter, hazard_cnt.
module reg_scoreboard #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic [4:0]                 id_rs,
    input  logic [4:0]                 id_rt,
    input  logic                       id_rs_used,
    input  logic                       id_rt_used,
    input  logic                       id_long,
    input  logic                       ex_push,
    input  logic [4:0]                 ex_waddr,
    input  logic                       lwb_valid,
    input  logic [4:0]                 lwb_waddr,
    output logic                       stallreq,
    output logic [$clog2(DEPTH):0]     sb_count,
    output logic                       sb_full,
    output logic                       sb_empty,
    output logic                       sb_err,
    output logic [15:0]                hazard_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]       addr_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q;
    logic [15:0]      hcnt_q;

    logic             is_full;
    logic             is_empty;
    logic             push_req;
    logic             pop_req;
    logic             push_ok;
    logic             pop_ok;
    logic             err_set;
    logic [DEPTH-1:0] live;
    logic             hazard;
    logic             full_stall;

    always_comb begin
        is_full  = (cnt_q == FULL_CNT);
        is_empty = (cnt_q == '0);
        push_req = ex_push && (ex_waddr != 5'd0) && !flush;
        pop_req  = lwb_valid && !flush;
        pop_ok   = pop_req && !is_empty;
        // a pop frees a slot in the same edge, so push into a full table
        // is legal as long as the head is leaving
        push_ok  = push_req && (!is_full || pop_ok);
        err_set  = (push_req && is_full && !pop_ok)
                || (pop_req && is_empty)
                || (pop_ok && (lwb_waddr != addr_q[head_q]));

        // the head being written back this cycle no longer blocks ID
        live = vld_q;
        if (pop_ok) begin
            live[head_q] = 1'b0;
        end

        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                if (id_rs_used && (id_rs != 5'd0) && (addr_q[i] == id_rs)) begin
                    hazard = 1'b1;
                end
                if (id_rt_used && (id_rt != 5'd0) && (addr_q[i] == id_rt)) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard     = hazard && id_valid;
        full_stall = id_valid && id_long && is_full && !lwb_valid;
        stallreq   = !flush && (hazard || full_stall);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            hcnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
            end
        end else begin
            if (stallreq && (hcnt_q != 16'hFFFF)) begin
                hcnt_q <= hcnt_q + 16'd1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                vld_q  <= '0;
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (pop_ok) begin
                    vld_q[head_q] <= 1'b0;
                    head_q        <= head_q + 1'b1;
                end
                // push after pop: when full, tail==head and the new
                // entry must win over the invalidation
                if (push_ok) begin
                    vld_q[tail_q]  <= 1'b1;
                    addr_q[tail_q] <= ex_waddr;
                    tail_q         <= tail_q + 1'b1;
                end
                if (push_ok && !pop_ok) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (pop_ok && !push_ok) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign sb_count   = cnt_q;
    assign sb_full    = is_full;
    assign sb_empty   = is_empty;
    assign sb_err     = err_q;
    assign hazard_cnt = hcnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_reg_scoreboard;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_long;
    logic       ex_push;
    logic [4:0] ex_waddr;
    logic       lwb_valid;
    logic [4:0] lwb_waddr;
    logic       stallreq;
    logic [2:0] sb_count;
    logic       sb_full;
    logic       sb_empty;
    logic       sb_err;
    logic [15:0] hazard_cnt;

    int checks = 0;
    int failures = 0;

    reg_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_long(id_long), .ex_push(ex_push), .ex_waddr(ex_waddr),
        .lwb_valid(lwb_valid), .lwb_waddr(lwb_waddr),
        .stallreq(stallreq), .sb_count(sb_count), .sb_full(sb_full),
        .sb_empty(sb_empty), .sb_err(sb_err), .hazard_cnt(hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // reference model: plain queue of pending destinations
    logic [4:0] q[$];
    bit         m_err = 0;
    int         m_hcnt = 0;

    function automatic bit m_stall();
        bit popping;
        if (flush || !id_valid) return 1'b0;
        popping = lwb_valid && (q.size() > 0);
        for (int i = popping ? 1 : 0; i < q.size(); i++) begin
            if (id_rs_used && id_rs != 0 && q[i] == id_rs) return 1'b1;
            if (id_rt_used && id_rt != 0 && q[i] == id_rt) return 1'b1;
        end
        return id_long && (q.size() == DEPTH) && !lwb_valid;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_err  = 0;
            m_hcnt = 0;
        end else begin
            if (m_stall() && m_hcnt < 65535) m_hcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (lwb_valid) begin
                    if (q.size() == 0) begin
                        m_err = 1;
                    end else begin
                        if (q[0] != lwb_waddr) m_err = 1;
                        void'(q.pop_front());
                    end
                end
                if (ex_push && ex_waddr != 0) begin
                    if (q.size() >= DEPTH) m_err = 1;
                    else q.push_back(ex_waddr);
                end
            end
        end
    end

    // per-cycle comparison, inputs are stable mid-cycle
    always @(negedge clk) begin
        chk("cyc_stallreq", 32'(stallreq), 32'(rst ? m_stall() : 1'b0));
        chk("cyc_count", 32'(sb_count), 32'(q.size()));
        chk("cyc_full", 32'(sb_full), 32'(q.size() == DEPTH));
        chk("cyc_empty", 32'(sb_empty), 32'(q.size() == 0));
        chk("cyc_err", 32'(sb_err), 32'(m_err));
        chk("cyc_hcnt", 32'(hazard_cnt), 32'(m_hcnt));
    end

    task automatic clear();
        flush = 0; id_valid = 0; id_rs = 0; id_rt = 0;
        id_rs_used = 0; id_rt_used = 0; id_long = 0;
        ex_push = 0; ex_waddr = 0; lwb_valid = 0; lwb_waddr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a);
        clear();
        ex_push = 1; ex_waddr = a;
        step();
    endtask

    task automatic pop(input logic [4:0] a);
        clear();
        lwb_valid = 1; lwb_waddr = a;
        step();
    endtask

    initial begin
        rst = 0;
        clear();
        repeat (2) step();
        chk("rst_count", 32'(sb_count), 0);
        chk("rst_empty", 32'(sb_empty), 1);
        chk("rst_full", 32'(sb_full), 0);
        chk("rst_err", 32'(sb_err), 0);
        chk("rst_hcnt", 32'(hazard_cnt), 0);
        chk("rst_stall", 32'(stallreq), 0);
        rst = 1;
        step();

        // RAW on a pending load, released by its own write-back
        push(5'd8);
        clear();
        id_valid = 1; id_rs = 8; id_rs_used = 1;
        #2 chk("raw_stall", 32'(stallreq), 1);
        step(); step(); step();
        lwb_valid = 1; lwb_waddr = 8;
        #2 chk("raw_release", 32'(stallreq), 0);
        chk("raw_hcnt", 32'(hazard_cnt), 3);
        step();
        clear();
        step();
        chk("raw_empty", 32'(sb_empty), 1);

        // fill table, full stall, push+pop while full
        push(5'd5); push(5'd6); push(5'd7); push(5'd9);
        chk("fill_full", 32'(sb_full), 1);
        chk("fill_count", 32'(sb_count), 4);
        clear();
        id_valid = 1; id_long = 1;
        #2 chk("full_stall", 32'(stallreq), 1);
        step();
        clear();
        ex_push = 1; ex_waddr = 10; lwb_valid = 1; lwb_waddr = 5;
        step();
        chk("swap_count", 32'(sb_count), 4);
        chk("swap_err", 32'(sb_err), 0);

        // overflow, drain, underflow
        push(5'd11);
        chk("ovf_err", 32'(sb_err), 1);
        chk("ovf_count", 32'(sb_count), 4);
        pop(5'd6); pop(5'd7); pop(5'd9); pop(5'd10);
        pop(5'd1);
        chk("unf_count", 32'(sb_count), 0);
        chk("unf_err", 32'(sb_err), 1);

        // flush clears entries, keeps err
        push(5'd3); push(5'd4);
        clear();
        flush = 1; id_valid = 1; id_rs = 3; id_rs_used = 1;
        #2 chk("flush_gate", 32'(stallreq), 0);
        step();
        chk("flush_count", 32'(sb_count), 0);
        chk("flush_empty", 32'(sb_empty), 1);
        chk("flush_err", 32'(sb_err), 1);
        clear();
        id_valid = 1; id_rs = 3; id_rt = 4; id_rs_used = 1; id_rt_used = 1;
        #2 chk("flush_read", 32'(stallreq), 0);
        step();

        // asynchronous reset mid-cycle with two entries
        push(5'd12); push(5'd13);
        clear();
        id_valid = 1; id_rt = 13; id_rt_used = 1;
        #2 chk("pre_arst_stall", 32'(stallreq), 1);
        #1 rst = 0;
        #1 chk("arst_count", 32'(sb_count), 0);
        chk("arst_stall", 32'(stallreq), 0);
        chk("arst_err", 32'(sb_err), 0);
        chk("arst_hcnt", 32'(hazard_cnt), 0);
        step();
        rst = 1;
        clear();
        step();

        // r0 never tracked nor matched
        push(5'd0);
        chk("r0_count", 32'(sb_count), 0);
        chk("r0_err", 32'(sb_err), 0);
        clear();
        id_valid = 1; id_rs = 0; id_rs_used = 1;
        #2 chk("r0_stall", 32'(stallreq), 0);
        step();

        // mismatched write-back still pops
        push(5'd14);
        pop(5'd15);
        chk("mis_count", 32'(sb_count), 0);
        chk("mis_err", 32'(sb_err), 1);

        // saturation of the stall counter
        push(5'd8);
        clear();
        id_valid = 1; id_rt = 8; id_rt_used = 1;
        for (int i = 0; i < 70000; i++) step();
        chk("sat_hcnt", 32'(hazard_cnt), 32'hFFFF);
        clear();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
